spi_master_sequencer: RTL and testbench

//  Command front-end directly upstream of the SPI master interface. Accepts {cfg, tx data} commands on a

---
 rtl/spi_master_sequencer_pkg.sv | 25 ++
 rtl/spi_master_sequencer.sv | 151 +++++++++++++++
 tb/tb_spi_master_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_sequencer_pkg.sv
// Shared definitions for the SPI master command sequencer.
// FSM state encodings and cfg word field offsets.
package spi_master_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_CFG_WAIT,
    ST_START,
    ST_BUSY,
    ST_RESP
  } seq_state_e;

  // cfg word is {cpol, cpha, width[wl-1:0]}
  localparam int CFG_WIDTH_LSB = 0;

  function automatic int cfg_cpha_bit(input int wl);
    return wl;
  endfunction

  function automatic int cfg_cpol_bit(input int wl);
    return wl + 1;
  endfunction

endpackage

// File: rtl/spi_master_sequencer.sv
// Command/response sequencer in front of an SPI master.
// Define SPI_SEQ_TIMEOUT_EN to add the BUSY-state watchdog.
module spi_master_sequencer
  import spi_master_sequencer_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int TIMEOUT_LOG       = 12,
  localparam int DW = 2**SPI_MAX_WIDTH_LOG,
  localparam int CW = SPI_MAX_WIDTH_LOG + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_cfg,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          config_req,
  output logic [CW-1:0] config_data,
  output logic          spi_start,
  input  logic          spi_finish,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  seq_state_e    state, state_nx;
  logic [CW-1:0] cfg_reg;
  logic          cfg_vld;
  logic          finish_d;
  logic          fin_edge;
  logic          accept;
  logic          timeout;

  assign fin_edge    = spi_finish & ~finish_d;
  assign accept      = cmd_valid & cmd_ready;
  assign busy        = (state != ST_IDLE);
  assign config_data = cfg_reg;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [TIMEOUT_LOG-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ST_START) begin
      wd_cnt <= '0;
    end else if (state == ST_BUSY) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // a finish edge on the saturating cycle takes priority
  assign timeout = (state == ST_BUSY) & ~fin_edge
                 & (&wd_cnt);
`else
  logic unused_timeout_log;
  assign unused_timeout_log = |TIMEOUT_LOG;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    config_req = 1'b0;
    spi_start  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!cfg_vld || cmd_cfg != cfg_reg) begin
            state_nx = ST_CFG;
          end else begin
            state_nx = ST_START;
          end
        end
      end
      ST_CFG: begin
        config_req = 1'b1;
        state_nx   = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: state_nx = ST_START;
      ST_START: begin
        spi_start = 1'b1;
        state_nx  = ST_BUSY;
      end
      ST_BUSY: begin
        if (fin_edge || timeout) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_reg   <= '0;
      cfg_vld   <= 1'b0;
      din       <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      frame_cnt <= '0;
      finish_d  <= 1'b0;
    end else begin
      finish_d <= spi_finish;
      if (accept) begin
        din     <= cmd_data;
        cfg_reg <= cmd_cfg;
      end
      if (state == ST_CFG) begin
        cfg_vld <= 1'b1;
      end
      if (state == ST_BUSY && fin_edge) begin
        rsp_data  <= dout;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (timeout) begin
        // abort: force a config resend on the next command
        rsp_data  <= '0;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        cfg_vld   <= 1'b0;
      end
      if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Randomized self-checking bench for spi_master_sequencer.
// Covers the watchdog when SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_master_sequencer;

  localparam int WL = 4;
  localparam int TL = 12;
  localparam int DW = 16;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_cfg = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          config_req;
  logic [CW-1:0] config_data;
  logic          spi_start;
  logic          spi_finish;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          busy;
  logic [15:0]   frame_cnt;

  logic          sl_fin = 1'b0;
  logic          glitch_fin = 1'b0;
  logic          stuck = 1'b0;
  logic          loopback = 1'b1;
  logic [DW-1:0] rnd_word = '0;
  logic [DW-1:0] sl_word = '0;
  logic [DW-1:0] dout_r = '0;
  int            sl_cnt = 0;
  int            sl_hi = 0;

  assign spi_finish = sl_fin | glitch_fin;
  assign dout       = dout_r;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_cfg = 0;
  int n_st = 0;
  int cfg_cyc = 0;
  int st_cyc = 0;
  logic [CW-1:0] cfg_seen = '0;

  logic [CW-1:0] m_cfg = '0;
  bit            m_vld = 1'b0;
  int            m_frames = 0;

  int            acc;
  int            w;
  logic [CW-1:0] rc;

  spi_master_sequencer #(
    .SPI_MAX_WIDTH_LOG(WL),
    .TIMEOUT_LOG(TL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_cfg(cmd_cfg),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .config_req(config_req),
    .config_data(config_data),
    .spi_start(spi_start),
    .spi_finish(spi_finish),
    .din(din),
    .dout(dout),
    .busy(busy),
    .frame_cnt(frame_cnt)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // strobe monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (config_req) begin
        n_cfg++;
        cfg_cyc  = cyc;
        cfg_seen = config_data;
      end
      if (spi_start) begin
        n_st++;
        st_cyc = cyc;
      end
    end
  end

  // SPI master stand-in: random frame time, level finish of 1-3 cycles
  initial forever begin
    @(negedge clk);
    if (rst || stuck) begin
      sl_cnt = 0;
      sl_hi  = 0;
      sl_fin = 1'b0;
    end else if (spi_start) begin
      sl_cnt  = $urandom_range(1, 6);
      sl_hi   = 0;
      sl_fin  = 1'b0;
      sl_word = loopback ? din : rnd_word;
    end else if (sl_cnt > 0) begin
      sl_cnt--;
      if (sl_cnt == 0) begin
        dout_r = sl_word;
        sl_fin = 1'b1;
        sl_hi  = $urandom_range(1, 3);
      end
    end else if (sl_hi > 0) begin
      sl_hi--;
      if (sl_hi == 0) sl_fin = 1'b0;
    end
  end

  task automatic issue(input logic [CW-1:0] cfg,
                       input logic [DW-1:0] data,
                       output int acc_c);
    int wt;
    cmd_cfg   = cfg;
    cmd_data  = data;
    cmd_valid = 1'b1;
    wt = 0;
    while (!cmd_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    chk("accept_timely", 32'(wt < 50), 32'd1);
    acc_c = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [CW-1:0] cfg,
                         input logic [DW-1:0] data,
                         input int hold);
    int a, c0, s0, wt, bad;
    logic exp_cfg;
    logic [DW-1:0] exp_rsp;
    exp_cfg = !m_vld || cfg != m_cfg;
    exp_rsp = loopback ? data : rnd_word;
    c0 = n_cfg;
    s0 = n_st;
    issue(cfg, data, a);
    m_cfg = cfg;
    m_vld = 1'b1;
    chk("din", 32'(din), 32'(data));
    chk("config_data", 32'(config_data), 32'(cfg));
    wt = 0;
    while (!rsp_valid && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    chk("rsp_timely", 32'(wt < 100), 32'd1);
    m_frames++;
    chk("cfg_req_cnt", 32'(n_cfg - c0), exp_cfg ? 32'd1 : 32'd0);
    chk("start_cnt", 32'(n_st - s0), 32'd1);
    if (exp_cfg) begin
      chk("cfg_lat", 32'(cfg_cyc - a), 32'd1);
      chk("cfg_to_start", 32'(st_cyc - cfg_cyc), 32'd2);
      chk("cfg_word", 32'(cfg_seen), 32'(cfg));
    end else begin
      chk("start_lat", 32'(st_cyc - a), 32'd1);
    end
    chk("rsp_data", 32'(rsp_data), 32'(exp_rsp));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames % 65536));
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== exp_rsp || cmd_ready) bad++;
    end
    chk("rsp_hold", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_config_req"}, 32'(config_req), 32'd0);
    chk({tag, "_spi_start"}, 32'(spi_start), 32'd0);
    chk({tag, "_din"}, 32'(din), 32'd0);
    chk({tag, "_config_data"}, 32'(config_data), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    loopback = 1'b1;
    run_cmd(6'b00_1111, 16'hA5C3, 0);
    run_cmd(6'b00_1111, 16'h3C5A, 0);
    run_cmd(6'b11_0111, 16'h0F0F, 0);
    loopback = 1'b0;
    rnd_word = 16'hBEEF;
    run_cmd(6'b11_0111, 16'h1234, 10);

    glitch_fin = 1'b1;
    @(negedge clk);
    glitch_fin = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_fin_rsp", 32'(rsp_valid), 32'd0);
    chk("idle_fin_cnt", 32'(frame_cnt), 32'(m_frames));
    chk("idle_fin_busy", 32'(busy), 32'd0);

    repeat (40) begin
      case ($urandom_range(0, 2))
        0:       rc = 6'b00_1111;
        1:       rc = 6'b11_0111;
        default: rc = 6'(($urandom_range(0, 63)));
      endcase
      loopback = 1'($urandom_range(0, 1));
      rnd_word = 16'($urandom);
      run_cmd(rc, 16'($urandom), $urandom_range(0, 4));
    end

    stuck = 1'b1;
    issue(6'b11_0111, 16'h5555, acc);
    repeat (60) @(negedge clk);
    chk("stall_no_rsp", 32'(rsp_valid), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    stuck = 1'b0;
    m_vld = 1'b0;
    m_frames = 0;
    loopback = 1'b1;
    run_cmd(6'b11_0111, 16'h6789, 0);

`ifdef SPI_SEQ_TIMEOUT_EN
    stuck = 1'b1;
    issue(6'b00_1111, 16'h7777, acc);
    m_cfg = 6'b00_1111;
    m_vld = 1'b1;
    w = 0;
    while (!rsp_valid && w < 6000) begin
      @(negedge clk);
      w++;
    end
    chk("wd_timely", 32'(w < 6000), 32'd1);
    chk("wd_len", 32'(cyc - st_cyc), 32'((1 << TL) + 1));
    chk("wd_err", 32'(rsp_err), 32'd1);
    chk("wd_data", 32'(rsp_data), 32'd0);
    chk("wd_frame_cnt", 32'(frame_cnt), 32'(m_frames));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    stuck = 1'b0;
    m_vld = 1'b0;
    run_cmd(6'b00_1111, 16'h8888, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
